// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter slice.
// Arbiter FSM states and the registered operation kind.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/rr_priority_select.sv
// Rotating priority picker: first requester at or after start.
// Returns valid plus the winning index.
module rr_priority_select #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  int j;

  // Walk offsets from the far end so the nearest offset wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = (int'(start) + i) % NUM_PORTS;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Arbitrates NUM_PORTS cache requesters onto one memory port.
// Round-robin or fixed priority, one transaction in flight.
module mem_arbiter_rr
  import rv32i_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int RR_MODE    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            req_resp,
  output logic [NUM_PORTS-1:0]            req_error,
  output logic [LINE_WIDTH-1:0]           cache_rdata,
  output logic                            pmem_read,
  output logic                            pmem_write,
  output logic [ADDR_WIDTH-1:0]           pmem_address,
  output logic [LINE_WIDTH-1:0]           pmem_wdata,
  input  logic                            pmem_resp,
  input  logic                            pmem_error,
  input  logic [LINE_WIDTH-1:0]           pmem_rdata
);

  localparam int IW = $clog2(NUM_PORTS);

  arb_state_t state_q, state_d;
  arb_op_t    op_q;

  logic [IW-1:0]         grant_q;
  logic [IW-1:0]         rr_ptr_q;
  logic [IW-1:0]         rr_ptr_nxt;
  logic [IW-1:0]         start;
  logic [IW-1:0]         sel_idx;
  logic                  sel_valid;
  logic [NUM_PORTS-1:0]  req_any;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  done_ev;

  assign req_any     = req_read | req_write;
  assign done_ev     = pmem_resp | pmem_error;
  assign cache_rdata = pmem_rdata;
  assign start       = (RR_MODE != 0) ? rr_ptr_q : '0;

  assign rr_ptr_nxt =
    (RR_MODE == 0)                  ? '0 :
    (grant_q == IW'(NUM_PORTS - 1)) ? '0 :
                                      grant_q + 1'b1;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IW)
  ) u_sel (
    .req   (req_any),
    .start (start),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && sel_valid) begin
        grant_q <= sel_idx;
        op_q    <= req_write[sel_idx] ? OP_WRITE : OP_READ;
        addr_q  <= req_address[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= req_wdata[int'(sel_idx)*LINE_WIDTH +: LINE_WIDTH];
      end
      if (state_q == BUSY && done_ev) begin
        rr_ptr_q <= rr_ptr_nxt;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_valid) state_d = BUSY;
      BUSY:    if (done_ev)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only BUSY talks to memory; everything else is quiet.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    req_resp     = '0;
    req_error    = '0;
    if (state_q == BUSY) begin
      pmem_read    = (op_q == OP_READ);
      pmem_write   = (op_q == OP_WRITE);
      pmem_address = addr_q;
      pmem_wdata   = wdata_q;
      req_resp[grant_q]  = pmem_resp;
      req_error[grant_q] = pmem_error;
    end
  end

endmodule
